// File: rtl/pc_tx_status_frm_pkg.sv
// Shared types and constants for the PC TX status-frame generator.
package pc_tx_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } st_e;

  localparam int HDR_LEN    = 16;
  localparam int WORD_BYTES = 4;

  // Total bytes on the wire, including the length prefix itself.
  function automatic int frame_len(input int ch_num, input int csum_en);
    return HDR_LEN + WORD_BYTES * ch_num + csum_en;
  endfunction

endpackage

// File: rtl/pc_tx_status_frm_if.sv
// Byte-writer handshake between a frame source and the PC TX arbiter.
interface pc_tx_status_frm_if;
  logic       status_wr_req;
  logic       status_wr_ack;
  logic       status_wr_done;
  logic       status_wr_en;
  logic [7:0] status_wr_data;

  modport master (
    output status_wr_req, status_wr_done, status_wr_en, status_wr_data,
    input  status_wr_ack
  );

  modport slave (
    input  status_wr_req, status_wr_done, status_wr_en, status_wr_data,
    output status_wr_ack
  );
endinterface

// File: rtl/pc_tx_status_frm_timer.sv
// Period timer, frame-pending flag and saturating overrun counter.
module pc_tx_status_timer (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [31:0] i_waittime,
  input  logic        i_trig,
  input  logic        i_leave_idle,
  output logic        o_pending,
  output logic [15:0] o_overrun_cnt
);

  logic [31:0] r_cnt;
  logic        r_pending;
  logic [15:0] r_overrun;
  logic        w_tick;
  logic        w_evt;

  assign w_tick = i_en && (r_cnt >= i_waittime);
  // A tick and a manual trigger in the same cycle are one event.
  assign w_evt  = w_tick | i_trig;

  // Free-running period counter, parked at 0 while disabled.
  always_ff @(posedge clk_sys) begin
    if (!rst_n)      r_cnt <= 32'd0;
    else if (!i_en)  r_cnt <= 32'd0;
    else if (w_tick) r_cnt <= 32'd0;
    else             r_cnt <= r_cnt + 32'd1;
  end

  // Pending flag: a new event wins over the FSM consuming the old one.
  always_ff @(posedge clk_sys) begin
    if (!rst_n)            r_pending <= 1'b0;
    else if (w_evt)        r_pending <= 1'b1;
    else if (i_leave_idle) r_pending <= 1'b0;
  end

  // Count events that arrive while a request is already queued.
  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      r_overrun <= 16'd0;
    else if (w_evt && r_pending && (r_overrun != 16'hFFFF))
      r_overrun <= r_overrun + 16'd1;
  end

  assign o_pending     = r_pending;
  assign o_overrun_cnt = r_overrun;

endmodule

// File: rtl/pc_tx_status_frm.sv
// Periodic / triggered status-frame source for the PC TX byte writer.
module pc_tx_status_frm
  import pc_tx_status_pkg::*;
#(
  parameter int U_DLY   = 1,
  parameter int CH_NUM  = 4,
  parameter int CSUM_EN = 1
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 cfg_status_en,
  input  logic [31:0]          cfg_status_waittime,
  input  logic [7:0]           cfg_frame_type,
  input  logic                 status_trig,
  input  logic [63:0]          debug_local_time,
  input  logic [CH_NUM*32-1:0] debug_mon_data,
  pc_tx_status_frm_if.master   wr_if,
  output logic [7:0]           status_seq,
  output logic [15:0]          status_overrun_cnt
);

  localparam int                FRAME_LEN  = frame_len(CH_NUM, CSUM_EN);
  localparam int                IDX_W      = 8;
  localparam int                MON_W      = CH_NUM * 32;
  localparam int                MON_IW     = $clog2(MON_W);
  localparam logic [31:0]       C_LEN32    = 32'(FRAME_LEN);
  localparam logic [IDX_W-1:0]  C_LAST     = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0]  C_DATA_END = IDX_W'(HDR_LEN + WORD_BYTES * CH_NUM);

  // U_DLY is accepted for drop-in compatibility; registers here update on the edge.
  if (U_DLY < 0 || CH_NUM < 1 || CH_NUM > 32) begin : g_bad_param
  end

  st_e              r_state, w_state_nxt;
  logic             r_req, r_done, r_en;
  logic [7:0]       r_data, r_csum, r_seq, r_type;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_time;
  logic [MON_W-1:0] r_mon;

  logic             w_req_nxt, w_done_nxt, w_en_nxt, w_snap, w_emit, w_leave_idle;
  logic [7:0]       w_data_nxt, w_csum_nxt, w_seq_nxt, w_byte;
  logic [IDX_W-1:0] w_idx_nxt, w_off;
  logic [MON_IW-1:0] w_mon_bit;
  logic             w_pending;

  pc_tx_status_timer u_timer (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .i_en          (cfg_status_en),
    .i_waittime    (cfg_status_waittime),
    .i_trig        (status_trig),
    .i_leave_idle  (w_leave_idle),
    .o_pending     (w_pending),
    .o_overrun_cnt (status_overrun_cnt)
  );

  // Byte mux over the snapshot; the first four bytes are constant so byte 0
  // can be launched on the grant edge before the snapshot lands.
  always_comb begin
    w_byte    = 8'h00;
    w_off     = r_idx - IDX_W'(HDR_LEN);
    w_mon_bit = MON_IW'({w_off[IDX_W-1:2], ~w_off[1:0], 3'b000});
    if (r_idx < IDX_W'(4))          w_byte = C_LEN32[{~r_idx[1:0], 3'b000} +: 8];
    else if (r_idx == IDX_W'(4))    w_byte = r_type;
    else if (r_idx == IDX_W'(5))    w_byte = r_seq;
    else if (r_idx < IDX_W'(8))     w_byte = 8'h00;
    else if (r_idx < IDX_W'(16))    w_byte = r_time[{~r_idx[2:0], 3'b000} +: 8];
    else if (r_idx < C_DATA_END)    w_byte = r_mon[w_mon_bit +: 8];
    else                            w_byte = r_csum;
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_en_nxt     = 1'b0;
    w_data_nxt   = 8'h00;
    w_idx_nxt    = r_idx;
    w_csum_nxt   = r_csum;
    w_seq_nxt    = r_seq;
    w_snap       = 1'b0;
    w_emit       = 1'b0;
    w_leave_idle = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt  = '0;
        w_csum_nxt = 8'h00;
        if (w_pending) begin
          w_state_nxt  = ST_REQ;
          w_req_nxt    = 1'b1;
          w_leave_idle = 1'b1;
        end
      end
      ST_REQ: begin
        if (wr_if.status_wr_ack) begin
          w_state_nxt = ST_SEND;
          w_snap      = 1'b1;
          w_emit      = 1'b1;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        if (r_idx == C_LAST) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_emit = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_seq_nxt   = r_seq + 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_emit) begin
      w_en_nxt   = 1'b1;
      w_data_nxt = w_byte;
      w_csum_nxt = r_csum + w_byte;
      w_idx_nxt  = r_idx + IDX_W'(1);
    end
  end

  // FSM state, registered outputs, byte index and running checksum.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
      r_idx   <= '0;
      r_csum  <= 8'h00;
      r_seq   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
      r_en    <= w_en_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_csum  <= w_csum_nxt;
      r_seq   <= w_seq_nxt;
    end
  end

  // Freeze frame payload on the grant edge so later input changes cannot tear it.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_type <= 8'h00;
      r_time <= 64'd0;
      r_mon  <= '0;
    end else if (w_snap) begin
      r_type <= cfg_frame_type;
      r_time <= debug_local_time;
      r_mon  <= debug_mon_data;
    end
  end

  assign wr_if.status_wr_req  = r_req;
  assign wr_if.status_wr_done = r_done;
  assign wr_if.status_wr_en   = r_en;
  assign wr_if.status_wr_data = r_data;
  assign status_seq           = r_seq;

endmodule

// File: tb/tb_pc_tx_status_frm.sv
// Self-checking bench: timeline model of frames plus directed literal pins.
module tb_pc_tx_status_frm;
  localparam int CH = 2;
  localparam int LA = 25;
  localparam logic [7:0] EXP_A [LA] = '{
    8'h00, 8'h00, 8'h00, 8'h19, 8'hA5, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h46};

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic            rst_n = 1'b0;
  logic            cfg_en = 1'b0;
  logic [31:0]     cfg_wait = 32'd0;
  logic [7:0]      cfg_type = 8'h00;
  logic            trig = 1'b0, trig_b = 1'b0;
  logic [63:0]     ltime = 64'd0;
  logic [CH*32-1:0] mon = '0;
  logic [7:0]      seq_a, seq_b;
  logic [15:0]     ov_a, ov_b;

  pc_tx_status_frm_if ifa();
  pc_tx_status_frm_if ifb();

  pc_tx_status_frm #(.U_DLY(1), .CH_NUM(CH), .CSUM_EN(1)) u_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_status_en(cfg_en),
    .cfg_status_waittime(cfg_wait), .cfg_frame_type(cfg_type),
    .status_trig(trig), .debug_local_time(ltime), .debug_mon_data(mon),
    .wr_if(ifa), .status_seq(seq_a), .status_overrun_cnt(ov_a));

  pc_tx_status_frm #(.U_DLY(1), .CH_NUM(CH), .CSUM_EN(0)) u_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_status_en(1'b0),
    .cfg_status_waittime(cfg_wait), .cfg_frame_type(cfg_type),
    .status_trig(trig_b), .debug_local_time(ltime), .debug_mon_data(mon),
    .wr_if(ifb), .status_seq(seq_b), .status_overrun_cnt(ov_b));

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  // A frame is described by the cycle it leaves idle and the cycle ack is
  // driven; every output window follows from those two numbers and LA.
  int          m_leave = -1000, m_ack = -1000, m_idle = 0;
  bit          m_pend = 0;
  int          m_ov = 0;
  logic [7:0]  m_seq = 8'h00;
  logic [31:0] m_tcnt = 32'd0;
  logic [7:0]  m_frame [LA];
  int          g_ack_dly = 0;
  bit          g_spur = 0;
  bit          chk_on = 0;

  task automatic build_frame();
    int s;
    s = 0;
    for (int i = 0; i < LA; i++) begin
      logic [7:0] b;
      if (i < 4)            b = 8'((LA >> (8 * (3 - i))) & 255);
      else if (i == 4)      b = cfg_type;
      else if (i == 5)      b = m_seq;
      else if (i < 8)       b = 8'h00;
      else if (i < 16)      b = 8'(ltime >> (8 * (15 - i)));
      else if (i < 16 + 4 * CH) begin
        int w, j;
        w = (i - 16) / 4;
        j = (i - 16) % 4;
        b = 8'(mon >> (32 * w + 8 * (3 - j)));
      end
      else                  b = 8'(s);
      m_frame[i] = b;
      s += int'(b);
    end
  endtask

  task automatic model_step();
    int n, d;
    bit tick, evt, leave;
    n = cyc;
    if (!rst_n) begin
      m_pend = 0; m_ov = 0; m_seq = 8'h00; m_tcnt = 32'd0;
      m_leave = -1000; m_ack = -1000; m_idle = n + 1;
    end else begin
      tick = cfg_en && (m_tcnt >= cfg_wait);
      if (!cfg_en || tick) m_tcnt = 32'd0;
      else                 m_tcnt = m_tcnt + 32'd1;
      evt   = tick || trig;
      leave = (n >= m_idle) && m_pend;
      if (evt && m_pend && m_ov != 65535) m_ov++;
      if (evt)        m_pend = 1;
      else if (leave) m_pend = 0;
      if (leave) begin
        d = (g_ack_dly > 0) ? g_ack_dly : int'($urandom_range(1, 5));
        m_leave = n;
        m_ack   = n + d;
        m_idle  = n + d + LA + 2;
      end
      if (n == m_ack) build_frame();
      if (n == m_ack + LA + 1) m_seq = m_seq + 8'd1;
    end
    cyc = n + 1;
  endtask

  // Model step on every edge, then drive ack for the new cycle.
  initial begin
    ifa.status_wr_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      model_step();
      #1;
      ifa.status_wr_ack = (cyc == m_ack) ||
        (g_spur && !(cyc > m_leave && cyc <= m_ack) && ($urandom_range(0, 5) == 0));
    end
  end

  // Per-cycle comparison against the model.
  bit e_req, e_en, e_done;
  initial forever begin
    @(negedge clk_sys);
    if (chk_on) begin
      e_req  = (cyc > m_leave) && (cyc <= m_ack);
      e_en   = (cyc > m_ack) && (cyc <= m_ack + LA);
      e_done = (cyc == m_ack + LA + 1);
      chk("req", ifa.status_wr_req, e_req);
      chk("wr_en", ifa.status_wr_en, e_en);
      chk("done", ifa.status_wr_done, e_done);
      if (e_en) chk("data", ifa.status_wr_data, m_frame[cyc - m_ack - 1]);
      chk("seq", seq_a, m_seq);
      chk("overrun", ov_a, 64'(m_ov));
    end
  end

  // Capture of DUT A activity for the directed literal checks.
  logic [7:0] cap [$];
  int rise_q [$];
  int n_done = 0, done_cyc = 0, last_en_cyc = 0;
  bit prev_req = 0;
  initial forever begin
    @(negedge clk_sys);
    if (ifa.status_wr_en) begin cap.push_back(ifa.status_wr_data); last_en_cyc = cyc; end
    if (ifa.status_wr_done) begin n_done++; done_cyc = cyc; end
    if (ifa.status_wr_req && !prev_req) rise_q.push_back(cyc);
    prev_req = ifa.status_wr_req;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  logic [7:0] capb [$];
  int nd0, to, last, gap;

  initial begin
    ifb.status_wr_ack = 1'b0;
    rst_n = 1'b0;
    cycles(3);
    chk_on = 1;
    chk("rst_req", ifa.status_wr_req, 0);
    chk("rst_en", ifa.status_wr_en, 0);
    chk("rst_done", ifa.status_wr_done, 0);
    chk("rst_seq", seq_a, 0);
    chk("rst_ov", ov_a, 0);
    rst_n = 1'b1;
    cycles(2);

    // Directed frame with checksum.
    cfg_type = 8'hA5; ltime = 64'h0102030405060708; mon = {32'h55667788, 32'h11223344};
    g_ack_dly = 4; cap.delete(); nd0 = n_done;
    trig = 1'b1; cycles(1); trig = 1'b0; cycles(40);
    chk("a_len", cap.size(), LA);
    for (int i = 0; i < LA && i < cap.size(); i++) chk($sformatf("a_byte%0d", i), cap[i], EXP_A[i]);
    chk("a_done_gap", done_cyc - last_en_cyc, 1);
    chk("a_ndone", n_done - nd0, 1);
    chk("a_seq", seq_a, 1);

    // Directed frame without checksum on the second instance.
    trig_b = 1'b1; cycles(1); trig_b = 1'b0;
    to = 0;
    while (!ifb.status_wr_req && to < 10) begin cycles(1); to++; end
    chk("b_req_seen", ifb.status_wr_req, 1);
    cycles(3); ifb.status_wr_ack = 1'b1; cycles(1); ifb.status_wr_ack = 1'b0;
    capb.delete(); last = -1; gap = -1;
    for (int k = 0; k < 40; k++) begin
      if (ifb.status_wr_en) begin capb.push_back(ifb.status_wr_data); last = k; end
      if (ifb.status_wr_done) gap = k - last;
      cycles(1);
    end
    chk("b_len", capb.size(), 24);
    for (int i = 0; i < 24 && i < capb.size(); i++)
      chk($sformatf("b_byte%0d", i), capb[i], (i == 3) ? 8'h18 : EXP_A[i]);
    chk("b_done_gap", gap, 1);
    chk("b_seq", seq_b, 1);

    // Periodic ticks, one-cycle-late ack.
    g_ack_dly = 2; cfg_wait = 32'd99; rise_q.delete();
    cfg_en = 1'b1; cycles(420); cfg_en = 1'b0; cycles(40);
    chk("per_nreq", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size(); i++) chk("per_spacing", rise_q[i] - rise_q[i-1], 100);
    chk("per_ov", ov_a, 0);
    chk("per_seq", seq_a, 5);

    // Ack withheld while ticks keep arriving.
    g_ack_dly = 31; cfg_wait = 32'd4; nd0 = n_done;
    cfg_en = 1'b1; cycles(30); cfg_en = 1'b0;
    chk("ovr_cnt", ov_a, 4);
    chk("ovr_req_held", ifa.status_wr_req, 1);
    cycles(100);
    chk("ovr_ndone", n_done - nd0, 2);
    chk("ovr_seq", seq_a, 7);

    // Reset in the middle of a frame.
    g_ack_dly = 2; cap.delete(); nd0 = n_done;
    trig = 1'b1; cycles(1); trig = 1'b0;
    to = 0;
    while (cap.size() < 10 && to < 60) begin cycles(1); to++; end
    chk("mid_reached", (to < 60), 1);
    rst_n = 1'b0; cycles(1);
    chk("mid_en", ifa.status_wr_en, 0);
    chk("mid_req", ifa.status_wr_req, 0);
    chk("mid_seq", seq_a, 0);
    chk("mid_ov", ov_a, 0);
    rst_n = 1'b1; cycles(5);
    chk("mid_no_done", n_done - nd0, 0);
    cap.delete();
    trig = 1'b1; cycles(1); trig = 1'b0; cycles(40);
    chk("post_len", cap.size(), LA);
    chk("post_ndone", n_done - nd0, 1);
    chk("post_seq", seq_a, 1);

    // Randomised traffic: data churns every cycle, spurious acks outside REQ.
    g_ack_dly = 0; g_spur = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        cfg_en   = 1'($urandom_range(0, 1));
        cfg_wait = 32'($urandom_range(0, 12));
      end
      trig     = ($urandom_range(0, 9) == 0);
      cfg_type = 8'($urandom);
      ltime    = {$urandom, $urandom};
      mon      = {$urandom, $urandom};
      rst_n    = ($urandom_range(0, 499) != 0);
      cycles(1);
    end
    rst_n = 1'b1; cfg_en = 1'b0; trig = 1'b0; g_spur = 0;
    cycles(200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
